mysystem_nios2_mul_result_stage: RTL and testbench

Downstream consumer of the Nios II multiply cell's 64-bit product (`A_mul_cell_result`) in the `mysystem` CPU. It carries a destination tag alongside each multiply through the cell's two register stages, selects the low or high 32-bit half, and queues results in a small FIFO. From there it hands them to the register-file writeback port with a valid/ready handshake. It raises a stall request so the pipeline freezes the cell's enables when results cannot drain.

---
 rtl/mysystem_nios2_mul_pkg.sv | 18 +
 rtl/mysystem_nios2_mul_wb_fifo.sv | 44 ++++
 rtl/mysystem_nios2_mul_result_stage.sv | 106 ++++++++++
 tb/tb_mysystem_nios2_mul_result_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mysystem_nios2_mul_pkg.sv
// Shared types and default widths for the Nios II multiply result stage.
package mysystem_nios2_mul_pkg;

  localparam int MUL_DATA_W_DEF = 32;
  localparam int MUL_TAG_W_DEF  = 5;

  typedef enum logic {
    MUL_LO = 1'b0,
    MUL_HI = 1'b1
  } mul_half_e;

  typedef struct packed {
    logic                     valid;
    logic [MUL_TAG_W_DEF-1:0] dst;
    mul_half_e                half;
  } mul_tag_t;

endpackage

// File: rtl/mysystem_nios2_mul_wb_fifo.sv
// Small synchronous FIFO feeding the register-file writeback port.
module mysystem_nios2_mul_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mysystem_nios2_mul_result_stage.sv
// Tags multiplies through the cell's M/A stages, picks the product half and
// queues results for writeback, stalling the cell when the queue cannot drain.
module mysystem_nios2_mul_result_stage
  import mysystem_nios2_mul_pkg::*;
#(
  parameter int DATA_W = MUL_DATA_W_DEF,
  parameter int TAG_W  = MUL_TAG_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                E_mul_valid,
  input  logic [TAG_W-1:0]    E_mul_dst,
  input  logic                E_mul_hi,
  input  logic                M_en,
  input  logic                A_en,
  input  logic                flush,
  input  logic [2*DATA_W-1:0] A_mul_cell_result,
  input  logic                wb_ready,
  output logic                wb_valid,
  output logic [TAG_W-1:0]    wb_dst,
  output logic [DATA_W-1:0]   wb_data,
  output logic                stall_req,
  output logic                mul_busy
);

  logic             vm_q, vm_d, va_q, va_d;
  logic [TAG_W-1:0] dstm_q, dstm_d, dsta_q, dsta_d;
  mul_half_e        hm_q, hm_d, ha_q, ha_d;

  logic              fifo_full, fifo_empty, full_eff, push, pop;
  logic [DATA_W-1:0] sel;
  logic [TAG_W+DATA_W-1:0] head;

  assign pop       = wb_valid & wb_ready;
  assign full_eff  = fifo_full & ~pop;
  assign push      = va_q & ~full_eff & ~flush;
  assign stall_req = va_q & full_eff;

  always_comb begin
    vm_d   = vm_q;
    dstm_d = dstm_q;
    hm_d   = hm_q;
    va_d   = va_q;
    dsta_d = dsta_q;
    ha_d   = ha_q;
    if (M_en) begin
      vm_d   = E_mul_valid;
      dstm_d = E_mul_dst;
      hm_d   = mul_half_e'(E_mul_hi);
    end
    // A tag moves with the cell output register so it always matches the product.
    if (A_en) begin
      va_d   = vm_q;
      dsta_d = dstm_q;
      ha_d   = hm_q;
    end else if (push) begin
      va_d = 1'b0;
    end
    if (flush) begin
      vm_d = 1'b0;
      va_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vm_q   <= 1'b0;
      dstm_q <= '0;
      hm_q   <= MUL_LO;
      va_q   <= 1'b0;
      dsta_q <= '0;
      ha_q   <= MUL_LO;
    end else begin
      vm_q   <= vm_d;
      dstm_q <= dstm_d;
      hm_q   <= hm_d;
      va_q   <= va_d;
      dsta_q <= dsta_d;
      ha_q   <= ha_d;
    end
  end

  assign sel = (ha_q == MUL_HI) ? A_mul_cell_result[2*DATA_W-1:DATA_W]
                                : A_mul_cell_result[DATA_W-1:0];

  mysystem_nios2_mul_wb_fifo #(
    .W     (TAG_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({dsta_q, sel}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign wb_valid = ~fifo_empty;
  assign wb_dst   = head[TAG_W+DATA_W-1:DATA_W];
  assign wb_data  = head[DATA_W-1:0];
  assign mul_busy = vm_q | va_q | ~fifo_empty;

endmodule

// File: tb/tb_mysystem_nios2_mul_result_stage.sv
// Directed bench with a scoreboard of expected writebacks and a model of the
// multiply cell's M/A product registers.
module tb_mysystem_nios2_mul_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_mul_valid;
  logic [4:0]  E_mul_dst;
  logic        E_mul_hi;
  logic        M_en, A_en;
  logic        run_en;
  logic        flush;
  logic [63:0] A_mul_cell_result;
  logic        wb_ready;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        stall_req;
  logic        mul_busy;

  logic [63:0] e_prod, prod_m, prod_a;
  logic [36:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mysystem_nios2_mul_result_stage dut (
    .clk               (clk),
    .reset             (reset),
    .E_mul_valid       (E_mul_valid),
    .E_mul_dst         (E_mul_dst),
    .E_mul_hi          (E_mul_hi),
    .M_en              (M_en),
    .A_en              (A_en),
    .flush             (flush),
    .A_mul_cell_result (A_mul_cell_result),
    .wb_ready          (wb_ready),
    .wb_valid          (wb_valid),
    .wb_dst            (wb_dst),
    .wb_data           (wb_data),
    .stall_req         (stall_req),
    .mul_busy          (mul_busy)
  );

  // Pipeline freezes both cell enables while a stall is requested.
  assign M_en = run_en & ~stall_req;
  assign A_en = run_en & ~stall_req;
  assign A_mul_cell_result = prod_a;

  always @(posedge clk) begin
    if (M_en) prod_m <= e_prod;
    if (A_en) prod_a <= prod_m;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] dst, input logic hi, input logic [63:0] prod,
                       input bit expect_wb);
    E_mul_valid = 1'b1;
    E_mul_dst   = dst;
    E_mul_hi    = hi;
    e_prod      = prod;
    if (expect_wb) exp_q.push_back({dst, (hi ? prod[63:32] : prod[31:0])});
    tick();
    E_mul_valid = 1'b0;
    e_prod      = 64'h0;
  endtask

  // Every accepted writeback is compared against the oldest expected result.
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_wb observed_dst=%0d observed_data=%0h expected=none", wb_dst, wb_data);
      end
      if (exp_q.size() != 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert ({wb_dst, wb_data} === e) else begin
          n_bad++;
          $error("FAIL wb_pop observed=%0d/%0h expected=%0d/%0h", wb_dst, wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; run_en = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    E_mul_valid = 1'b0; E_mul_dst = '0; E_mul_hi = 1'b0; e_prod = '0;
    tick(); tick();
    check("rst_wb_valid", 64'(wb_valid), 64'h0);
    check("rst_wb_dst", 64'(wb_dst), 64'h0);
    check("rst_wb_data", 64'(wb_data), 64'h0);
    check("rst_stall", 64'(stall_req), 64'h0);
    check("rst_busy", 64'(mul_busy), 64'h0);
    reset = 1'b0;

    // low half, latency of three edges
    wb_ready = 1'b1;
    issue(5'd3, 1'b0, 64'h0000_0001_FFFF_FFFE, 1'b1);
    check("lo_valid_t0", 64'(wb_valid), 64'h0);
    check("lo_busy_t0", 64'(mul_busy), 64'h1);
    tick();
    check("lo_valid_t1", 64'(wb_valid), 64'h0);
    tick();
    check("lo_valid_t2", 64'(wb_valid), 64'h1);
    check("lo_dst", 64'(wb_dst), 64'd3);
    check("lo_data", 64'(wb_data), 64'hFFFF_FFFE);
    tick();
    check("lo_valid_after_pop", 64'(wb_valid), 64'h0);
    check("lo_busy_after_pop", 64'(mul_busy), 64'h0);

    // high half
    issue(5'd9, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
    tick(); tick();
    check("hi_dst", 64'(wb_dst), 64'd9);
    check("hi_data", 64'(wb_data), 64'h8000_0000);
    tick();

    // backpressure: two queued, third held in A
    wb_ready = 1'b0;
    issue(5'd1, 1'b0, 64'h1111_1111_2222_2222, 1'b1);
    issue(5'd2, 1'b1, 64'h3333_3333_4444_4444, 1'b1);
    issue(5'd4, 1'b0, 64'h5555_5555_6666_6666, 1'b1);
    tick();
    check("bp_stall", 64'(stall_req), 64'h1);
    check("bp_head_dst", 64'(wb_dst), 64'd1);
    tick(); tick();
    check("bp_stall_held", 64'(stall_req), 64'h1);
    check("bp_head_held", 64'({wb_dst, wb_data}), 64'({5'd1, 32'h2222_2222}));
    wb_ready = 1'b1;
    #1;
    check("bp_stall_drop_same_cycle", 64'(stall_req), 64'h0);
    tick();
    check("full_pushpop_valid", 64'(wb_valid), 64'h1);
    check("full_pushpop_dst", 64'(wb_dst), 64'd2);
    check("full_pushpop_stall", 64'(stall_req), 64'h0);
    tick();
    check("bp_third_dst", 64'(wb_dst), 64'd4);
    tick();
    check("bp_drained", 64'(wb_valid), 64'h0);
    check("bp_busy", 64'(mul_busy), 64'h0);

    // flush: earlier queued entry survives, dst=7 is killed
    wb_ready = 1'b0;
    issue(5'd5, 1'b0, 64'h0000_0000_0000_0055, 1'b1);
    tick(); tick();
    issue(5'd7, 1'b0, 64'h0000_0000_0000_0077, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_head_dst", 64'(wb_dst), 64'd5);
    wb_ready = 1'b1;
    tick();
    check("fl_no_dst7", 64'(wb_valid), 64'h0);
    tick(); tick();
    check("fl_still_empty", 64'(wb_valid), 64'h0);
    check("fl_busy", 64'(mul_busy), 64'h0);

    // reset with a full queue and a held A entry
    wb_ready = 1'b0;
    issue(5'd10, 1'b0, 64'hAAAA_AAAA_0000_000A, 1'b0);
    issue(5'd11, 1'b0, 64'hBBBB_BBBB_0000_000B, 1'b0);
    issue(5'd12, 1'b0, 64'hCCCC_CCCC_0000_000C, 1'b0);
    tick();
    check("mr_stall_before", 64'(stall_req), 64'h1);
    reset = 1'b1;
    tick();
    check("mr_wb_valid", 64'(wb_valid), 64'h0);
    check("mr_wb_dst", 64'(wb_dst), 64'h0);
    check("mr_wb_data", 64'(wb_data), 64'h0);
    check("mr_stall", 64'(stall_req), 64'h0);
    check("mr_busy", 64'(mul_busy), 64'h0);
    reset = 1'b0;
    wb_ready = 1'b1;
    repeat (5) tick();
    check("mr_no_stale", 64'(wb_valid), 64'h0);
    check("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
